// File: rtl/elastic_stage_reg.sv
// Two-entry (main + skid) elastic pipeline register with registered in_ready and synchronous flush.
// Define ELASTIC_STAGE_PERF_EN to add saturating stall_cnt / bubble_cnt performance counters.
module elastic_stage_reg #(
  parameter int unsigned DATA_W   = 128,
  parameter bit          CLR_DATA = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
`ifdef ELASTIC_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  // State is the pair {sv, mv}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } stateT;

  stateT             state, stateNext;
  logic [DATA_W-1:0] md, sd, mdNext, sdNext;
  logic              mv, sv, push, pop;

  assign mv = state[0];
  assign sv = state[1];

  // A transfer happens on an edge where valid & ready are both high on that side;
  // valid never depends on ready, and in_ready depends only on registered state.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign in_ready  = ~sv;
  assign out_valid = mv;
  assign out_data  = md;
  assign occupancy = {1'b0, mv} + {1'b0, sv};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= EMPTY;
      if (CLR_DATA) begin
        md <= '0;
        sd <= '0;
      end
    end else begin
      state <= stateNext;
      md    <= mdNext;
      sd    <= sdNext;
    end
  end

  always_comb begin
    stateNext = state;
    mdNext    = md;
    sdNext    = sd;
    case (state)
      EMPTY: begin
        if (push) begin
          stateNext = ONE;
          mdNext    = in_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          mdNext = in_data;
        end else if (push) begin
          stateNext = FULL;
          sdNext    = in_data;
        end else if (pop) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        // The skid entry moves forward so it is never overtaken.
        if (pop) begin
          stateNext = ONE;
          mdNext    = sd;
        end
      end
      default: stateNext = EMPTY;
    endcase
    if (flush) begin
      stateNext = EMPTY;
      if (CLR_DATA) begin
        mdNext = '0;
        sdNext = '0;
      end
    end
  end

`ifdef ELASTIC_STAGE_PERF_EN
  logic [CNT_W-1:0] stallCnt, bubbleCnt;

  assign stall_cnt  = stallCnt;
  assign bubble_cnt = bubbleCnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stallCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if (!out_valid && (bubbleCnt != '1)) begin
        bubbleCnt <= bubbleCnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Directed table-driven bench for elastic_stage_reg plus hand-written skid-order and counter sequences.
// Counter checks are compiled in when ELASTIC_STAGE_PERF_EN is defined.
module tb_elastic_stage_reg;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [1:0]    occupancy;
`ifdef ELASTIC_STAGE_PERF_EN
  logic [3:0]    stall_cnt;
  logic [3:0]    bubble_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  elastic_stage_reg #(.DATA_W(DW), .CLR_DATA(1'b1), .CNT_W(4)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .flush(flush),
`ifdef ELASTIC_STAGE_PERF_EN
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .occupancy(occupancy)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  typedef struct {
    logic          rstN;
    logic          flush;
    logic          inValid;
    logic [DW-1:0] inData;
    logic          outReady;
    logic          expValid;
    logic [DW-1:0] expData;
    logic          chkData;
    logic          expReady;
    logic [1:0]    expOcc;
  } vecT;

  vecT tbl[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present inputs, take one edge, then sample away from the edge.
  task automatic step(input logic rstN, input logic fl, input logic iv,
                      input logic [DW-1:0] id, input logic ordy);
    nRST      = rstN;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input logic [DW-1:0] id,
                     input logic ordy, input logic ev, input logic [DW-1:0] ed,
                     input logic cd, input logic er, input logic [1:0] eo);
    vecT v;
    v = '{rstN: r, flush: f, inValid: iv, inData: id, outReady: ordy,
          expValid: ev, expData: ed, chkData: cd, expReady: er, expOcc: eo};
    tbl.push_back(v);
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];

    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;

    //    rst fl iv data  ordy | ov data  chk ir occ
    // Reset then single push
    add(0, 0, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0);
    add(0, 0, 0, 8'h00, 0,   0, 8'h00, 1, 1, 0);
    add(1, 0, 1, 8'hA5, 1,   1, 8'hA5, 1, 1, 1);
    add(1, 0, 0, 8'h00, 1,   0, 8'h00, 0, 1, 0);
    // Back-to-back stream 1..8
    for (int k = 1; k <= 8; k++) add(1, 0, 1, DW'(k), 1, 1, DW'(k), 1, 1, 1);
    add(1, 0, 0, 8'h00, 1,   0, 8'h00, 0, 1, 0);
    // Stall fill, push ignored while full, drain in order
    add(1, 0, 1, 8'h11, 0,   1, 8'h11, 1, 1, 1);
    add(1, 0, 1, 8'h22, 0,   1, 8'h11, 1, 0, 2);
    add(1, 0, 1, 8'h99, 0,   1, 8'h11, 1, 0, 2);
    add(1, 0, 0, 8'h00, 1,   1, 8'h22, 1, 1, 1);
    add(1, 0, 0, 8'h00, 1,   0, 8'h00, 0, 1, 0);
    // Flush while FULL with a push pending
    add(1, 0, 1, 8'h44, 0,   1, 8'h44, 1, 1, 1);
    add(1, 0, 1, 8'h55, 0,   1, 8'h44, 1, 0, 2);
    add(1, 1, 1, 8'h33, 0,   0, 8'h00, 1, 1, 0);
    add(1, 0, 0, 8'h00, 1,   0, 8'h00, 1, 1, 0);
    // Flush in ONE beats a simultaneous push and pop
    add(1, 0, 1, 8'h66, 0,   1, 8'h66, 1, 1, 1);
    add(1, 1, 1, 8'h77, 1,   0, 8'h00, 1, 1, 0);
    // Reset mid-stream while FULL
    add(1, 0, 1, 8'h88, 0,   1, 8'h88, 1, 1, 1);
    add(1, 0, 1, 8'h9A, 0,   1, 8'h88, 1, 0, 2);
    add(0, 1, 1, 8'hAA, 1,   0, 8'h00, 1, 1, 0);
    add(1, 0, 0, 8'h00, 1,   0, 8'h00, 1, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rstN, tbl[i].flush, tbl[i].inValid, tbl[i].inData, tbl[i].outReady);
      check($sformatf("v%0d out_valid", i), DW'(out_valid), DW'(tbl[i].expValid));
      check($sformatf("v%0d in_ready", i), DW'(in_ready), DW'(tbl[i].expReady));
      check($sformatf("v%0d occupancy", i), DW'(occupancy), DW'(tbl[i].expOcc));
      if (tbl[i].chkData) check($sformatf("v%0d out_data", i), out_data, tbl[i].expData);
    end

    // Skid ordering: fill, then pop with a producer offering a new word every cycle.
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    step(1, 0, 1, 8'h10, 0);
    step(1, 0, 1, 8'h20, 0);
    check("skid full occ", DW'(occupancy), 8'd2);
    begin
      int idx;
      idx = 2;
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
        logic [DW-1:0] offer;
        offer = (idx < 4) ? DW'(8'h10 * (idx + 1)) : 8'h00;
        if (in_ready && idx < 4) idx++;
        check($sformatf("skid order %0d", c), out_data, exp_q[0]);
        exp_q.pop_front();
        step(1, 0, (offer != 0), offer, 1);
        if (!out_valid) break;
      end
      check("skid drained", DW'(exp_q.size()), 8'd0);
    end

`ifdef ELASTIC_STAGE_PERF_EN
    step(0, 0, 0, 8'h00, 0);
    check("perf reset stall", DW'(stall_cnt), 8'h0);
    check("perf reset bubble", DW'(bubble_cnt), 8'h0);
    for (int c = 0; c < 3; c++) step(1, 0, 0, 8'h00, 0);
    check("perf bubble 3", DW'(bubble_cnt), 8'h3);
    step(1, 0, 1, 8'hC3, 0);
    check("perf bubble 4", DW'(bubble_cnt), 8'h4);
    for (int c = 0; c < 20; c++) step(1, 0, 0, 8'h00, 0);
    check("perf stall sat", DW'(stall_cnt), 8'hF);
    check("perf bubble hold", DW'(bubble_cnt), 8'h4);
    step(1, 1, 0, 8'h00, 0);
    check("perf stall after flush", DW'(stall_cnt), 8'hF);
    check("perf bubble after flush", DW'(bubble_cnt), 8'h4);
    step(1, 0, 0, 8'h00, 0);
    check("perf bubble post flush", DW'(bubble_cnt), 8'h5);
`endif

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
